// File: rtl/debouncer_multi.sv
// debouncer_multi
//   N-channel debouncer for push-buttons, switches and slow board pins.
//   Each channel goes through a SYNC_STAGES flop synchronizer and then a
//   per-channel stability counter. The debounced level follows the
//   synchronized input only after STABLE_CYCLES consecutive stable cycles.
//   Level changes of the debounced output are also reported as one-cycle
//   rise/fall strobes plus a combined any_change flag.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   rstn       : asynchronous active-low reset
//   din        : raw asynchronous inputs, bit i = channel i
//   db_out     : debounced level per channel (registered)
//   rise       : one-cycle pulse after db_out[i] goes 0->1
//   fall       : one-cycle pulse after db_out[i] goes 1->0
//   any_change : OR of all rise/fall bits, aligned with them

module debouncer_multi #(
  parameter int   CHANNELS      = 2,
  parameter int   STABLE_CYCLES = 24,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam int CNT_WIDTH = $clog2(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]  s;
  logic [CHANNELS-1:0]  v;
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0]  db_q;

  // Synchronizer: the only logic that touches din.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= {CHANNELS{RESET_VALUE}};
      end
    end else begin
      sync_q[0] <= din;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_q[st-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-channel stability filter. The counter saturates at CNT_MAX so a
  // long stable input never wraps and never re-triggers a strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v      <= {CHANNELS{RESET_VALUE}};
      db_out <= {CHANNELS{RESET_VALUE}};
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (s[i] != v[i]) begin
          v[i]   <= s[i];
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db_out[i] <= v[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Edge strobes compare db_out against its previous value, so they land
  // exactly one cycle after the level change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_q       <= {CHANNELS{RESET_VALUE}};
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      db_q       <= db_out;
      rise       <= db_out & ~db_q;
      fall       <= ~db_out & db_q;
      any_change <= |(db_out ^ db_q);
    end
  end

endmodule
